// File: rtl/coin_accumulator_pkg.sv
// Shared constants and encodings for the coin accumulator front end.
package coin_pkg;

  localparam int unsigned CREDIT_W = 10;

  localparam logic [CREDIT_W-1:0] VAL_NICKEL  = 10'd5;
  localparam logic [CREDIT_W-1:0] VAL_DIME    = 10'd10;
  localparam logic [CREDIT_W-1:0] VAL_QUARTER = 10'd25;
  localparam logic [CREDIT_W-1:0] VAL_DOLLAR  = 10'd100;

  typedef enum logic {
    ACCEPT = 1'b0,
    CHANGE = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    CHG_NONE    = 2'd0,
    CHG_NICKEL  = 2'd1,
    CHG_DIME    = 2'd2,
    CHG_QUARTER = 2'd3
  } chg_e;

  // Largest coin that still fits in the amount owed (greedy change).
  function automatic chg_e pick_denom(input logic [CREDIT_W-1:0] amt);
    if (amt >= VAL_QUARTER)     return CHG_QUARTER;
    else if (amt >= VAL_DIME)   return CHG_DIME;
    else if (amt >= VAL_NICKEL) return CHG_NICKEL;
    else                        return CHG_NONE;
  endfunction

  function automatic logic [CREDIT_W-1:0] denom_value(input chg_e d);
    case (d)
      CHG_QUARTER: return VAL_QUARTER;
      CHG_DIME:    return VAL_DIME;
      CHG_NICKEL:  return VAL_NICKEL;
      default:     return '0;
    endcase
  endfunction

endpackage

// File: rtl/coin_accumulator_if.sv
// Coin, dispense and change signals between the accumulator and its environment.
interface coin_accumulator_if;
  import coin_pkg::*;

  logic                coin_nickel;
  logic                coin_dime;
  logic                coin_quarter;
  logic                coin_dollar;
  logic                cancel;
  logic                outbev1;
  logic                outbev2;
  logic                outbev3;
  logic [CREDIT_W-1:0] moneyin;
  logic                coin_reject;
  logic                chg_nickel;
  logic                chg_dime;
  logic                chg_quarter;
  logic                busy;

  modport slave (
    input  coin_nickel, coin_dime, coin_quarter, coin_dollar, cancel,
    input  outbev1, outbev2, outbev3,
    output moneyin, coin_reject, chg_nickel, chg_dime, chg_quarter, busy
  );

  modport master (
    output coin_nickel, coin_dime, coin_quarter, coin_dollar, cancel,
    output outbev1, outbev2, outbev3,
    input  moneyin, coin_reject, chg_nickel, chg_dime, chg_quarter, busy
  );

endinterface

// File: rtl/coin_accumulator_change_payout.sv
// Pays an owed amount back one coin at a time, largest coin first,
// spacing the coin pulses CHG_GAP cycles apart.
module change_payout
  import coin_pkg::*;
#(
  parameter int unsigned CHG_GAP = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [CREDIT_W-1:0] credit_in,
  output logic                done,
  output logic [CREDIT_W-1:0] remaining,
  output logic                chg_nickel,
  output logic                chg_dime,
  output logic                chg_quarter
);

  localparam int unsigned        GAP_W      = $clog2(CHG_GAP);
  localparam logic [GAP_W-1:0]   GAP_RELOAD = GAP_W'(CHG_GAP - 1);

  logic                active;
  logic [GAP_W-1:0]    gap_cnt;
  chg_e                pick;
  logic [CREDIT_W-1:0] pick_val;
  logic                fire;

  // Choose the next coin and decide whether it is emitted this cycle.
  always_comb begin
    pick     = pick_denom(remaining);
    pick_val = denom_value(pick);
    fire     = active && (gap_cnt == '0) && (pick != CHG_NONE);
  end

  // Pacing counter, remaining amount and registered coin pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      active      <= 1'b0;
      gap_cnt     <= '0;
      remaining   <= '0;
      done        <= 1'b0;
      chg_nickel  <= 1'b0;
      chg_dime    <= 1'b0;
      chg_quarter <= 1'b0;
    end else begin
      done        <= 1'b0;
      chg_nickel  <= 1'b0;
      chg_dime    <= 1'b0;
      chg_quarter <= 1'b0;
      if (load) begin
        active    <= 1'b1;
        remaining <= credit_in;
        gap_cnt   <= '0;
      end else if (fire) begin
        remaining   <= remaining - pick_val;
        gap_cnt     <= GAP_RELOAD;
        chg_nickel  <= (pick == CHG_NICKEL);
        chg_dime    <= (pick == CHG_DIME);
        chg_quarter <= (pick == CHG_QUARTER);
        // done rides alongside the final coin pulse
        if (remaining == pick_val) begin
          done   <= 1'b1;
          active <= 1'b0;
        end
      end else if (active && (gap_cnt != '0)) begin
        gap_cnt <= gap_cnt - 1'b1;
      end
    end
  end

endmodule

// File: rtl/coin_accumulator.sv
// Coin credit accumulator: coin arbitration, overflow check, price
// deduction and the ACCEPT/CHANGE control FSM; change payout is delegated.
module coin_accumulator
  import coin_pkg::*;
#(
  parameter int unsigned PRICE1     = 75,
  parameter int unsigned PRICE2     = 100,
  parameter int unsigned PRICE3     = 125,
  parameter int unsigned MAX_CREDIT = 995,
  parameter int unsigned CHG_GAP    = 4
) (
  input  logic               clk,
  input  logic               rst,
  coin_accumulator_if.slave  bus
);

  localparam logic [CREDIT_W-1:0] P1    = CREDIT_W'(PRICE1);
  localparam logic [CREDIT_W-1:0] P2    = CREDIT_W'(PRICE2);
  localparam logic [CREDIT_W-1:0] P3    = CREDIT_W'(PRICE3);
  localparam logic [CREDIT_W:0]   MAX_C = (CREDIT_W + 1)'(MAX_CREDIT);

  state_e              state, state_nxt;
  logic [CREDIT_W-1:0] credit, credit_nxt;
  logic                reject_nxt;
  logic                load;
  logic [CREDIT_W-1:0] load_credit;

  logic [3:0]          coins;
  logic                coin_any;
  logic                coin_multi;
  logic [CREDIT_W-1:0] coin_val;
  logic [CREDIT_W:0]   coin_sum;
  logic                bev_hit;
  logic [CREDIT_W-1:0] bev_price;
  logic                bev_ok;

  logic [CREDIT_W-1:0] moneyin_q;
  logic                busy_q;
  logic                reject_q;

  logic                pay_done;
  logic [CREDIT_W-1:0] pay_remaining;
  logic                pay_nickel;
  logic                pay_dime;
  logic                pay_quarter;

  // Coin and dispense arbitration.
  always_comb begin
    coins      = {bus.coin_dollar, bus.coin_quarter, bus.coin_dime, bus.coin_nickel};
    coin_any   = |coins;
    coin_multi = ($countones(coins) > 1);
    if (bus.coin_dollar)       coin_val = VAL_DOLLAR;
    else if (bus.coin_quarter) coin_val = VAL_QUARTER;
    else if (bus.coin_dime)    coin_val = VAL_DIME;
    else if (bus.coin_nickel)  coin_val = VAL_NICKEL;
    else                       coin_val = '0;
    coin_sum = {1'b0, credit} + {1'b0, coin_val};

    bev_hit = bus.outbev1 | bus.outbev2 | bus.outbev3;
    if (bus.outbev1)      bev_price = P1;
    else if (bus.outbev2) bev_price = P2;
    else                  bev_price = P3;
    bev_ok = bev_hit && (credit >= bev_price);
  end

  // Next state, next credit and coin rejection.
  always_comb begin
    state_nxt   = state;
    credit_nxt  = credit;
    reject_nxt  = 1'b0;
    load        = 1'b0;
    load_credit = credit;
    case (state)
      ACCEPT: begin
        if (bev_ok) begin
          credit_nxt = credit - bev_price;
          reject_nxt = coin_any;
          if (credit_nxt != '0) begin
            state_nxt   = CHANGE;
            load        = 1'b1;
            load_credit = credit_nxt;
          end
        end else if (bus.cancel && (credit != '0)) begin
          state_nxt   = CHANGE;
          load        = 1'b1;
          load_credit = credit;
          reject_nxt  = coin_any;
        end else if (coin_any) begin
          reject_nxt = coin_multi;
          if (coin_sum > MAX_C) reject_nxt = 1'b1;
          else                  credit_nxt = coin_sum[CREDIT_W-1:0];
        end
      end
      CHANGE: begin
        reject_nxt = coin_any;
        credit_nxt = pay_remaining;
        if (pay_done) state_nxt = ACCEPT;
      end
      default: state_nxt = ACCEPT;
    endcase
  end

  // State, credit and registered credit/status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ACCEPT;
      credit    <= '0;
      moneyin_q <= '0;
      busy_q    <= 1'b0;
      reject_q  <= 1'b0;
    end else begin
      state     <= state_nxt;
      credit    <= credit_nxt;
      moneyin_q <= (state_nxt == ACCEPT) ? credit_nxt : '0;
      busy_q    <= (state_nxt == CHANGE);
      reject_q  <= reject_nxt;
    end
  end

  change_payout #(
    .CHG_GAP (CHG_GAP)
  ) u_payout (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .credit_in   (load_credit),
    .done        (pay_done),
    .remaining   (pay_remaining),
    .chg_nickel  (pay_nickel),
    .chg_dime    (pay_dime),
    .chg_quarter (pay_quarter)
  );

  assign bus.moneyin     = moneyin_q;
  assign bus.busy        = busy_q;
  assign bus.coin_reject = reject_q;
  assign bus.chg_nickel  = pay_nickel;
  assign bus.chg_dime    = pay_dime;
  assign bus.chg_quarter = pay_quarter;

endmodule

// File: tb/tb_coin_accumulator.sv
// Directed bench for coin_accumulator with hand-computed expectations.
module tb_coin_accumulator;

  localparam logic [3:0] NOC  = 4'b0000;
  localparam logic [3:0] C_N  = 4'b0001;
  localparam logic [3:0] C_D  = 4'b0010;
  localparam logic [3:0] C_Q  = 4'b0100;
  localparam logic [3:0] C_DL = 4'b1000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  coin_accumulator_if bus();

  coin_accumulator #(
    .PRICE1     (75),
    .PRICE2     (100),
    .PRICE3     (125),
    .MAX_CREDIT (995),
    .CHG_GAP    (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int unsigned total = 0;
  int unsigned bad = 0;
  int unsigned multi_hot = 0;

  always @(negedge clk) begin
    if ((32'(bus.chg_nickel) + 32'(bus.chg_dime) + 32'(bus.chg_quarter)) > 1)
      multi_hot++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] coins, input logic [2:0] bevs, input logic cxl);
    {bus.coin_dollar, bus.coin_quarter, bus.coin_dime, bus.coin_nickel} = coins;
    {bus.outbev3, bus.outbev2, bus.outbev1} = bevs;
    bus.cancel = cxl;
    tick();
    {bus.coin_dollar, bus.coin_quarter, bus.coin_dime, bus.coin_nickel} = 4'b0000;
    {bus.outbev3, bus.outbev2, bus.outbev1} = 3'b000;
    bus.cancel = 1'b0;
  endtask

  task automatic drain(output int unsigned sum, output int unsigned nq,
                       output int unsigned nd, output int unsigned nn, output bit ok);
    sum = 0; nq = 0; nd = 0; nn = 0; ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!bus.busy) begin
        ok = 1'b1;
        break;
      end
      tick();
      if (bus.chg_quarter) begin nq++; sum += 25; end
      if (bus.chg_dime)    begin nd++; sum += 10; end
      if (bus.chg_nickel)  begin nn++; sum += 5;  end
    end
  endtask

  int unsigned sum, nq, nd, nn;
  bit          ok;
  logic        seen;

  initial begin
    drive_idle();
    #2 rst = 1'b0;
    repeat (3) tick();
    chk("rst_moneyin", 32'(bus.moneyin), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_reject", 32'(bus.coin_reject), 0);
    chk("rst_chg", 32'({bus.chg_nickel, bus.chg_dime, bus.chg_quarter}), 0);
    rst = 1'b1;
    tick();

    // three quarters then an exact-price vend
    drive(C_Q, 3'b000, 1'b0); chk("q1", 32'(bus.moneyin), 25);
    chk("q1_noreject", 32'(bus.coin_reject), 0);
    tick(); tick();
    drive(C_Q, 3'b000, 1'b0); chk("q2", 32'(bus.moneyin), 50);
    tick(); tick();
    drive(C_Q, 3'b000, 1'b0); chk("q3", 32'(bus.moneyin), 75);
    drive(NOC, 3'b001, 1'b0);
    chk("vend1_moneyin", 32'(bus.moneyin), 0);
    chk("vend1_busy", 32'(bus.busy), 0);
    seen = 1'b0;
    repeat (6) begin
      tick();
      seen |= bus.busy | bus.chg_nickel | bus.chg_dime | bus.chg_quarter;
    end
    chk("vend1_no_change", 32'(seen), 0);

    // 125 credit, vend 75, two quarters back at E+1 and E+5
    drive(C_DL, 3'b000, 1'b0);
    drive(C_Q, 3'b000, 1'b0); chk("c125", 32'(bus.moneyin), 125);
    drive(NOC, 3'b001, 1'b0);
    chk("e_busy", 32'(bus.busy), 1);
    chk("e_moneyin", 32'(bus.moneyin), 0);
    chk("e_chg", 32'(bus.chg_quarter), 0);
    tick();
    chk("e1_quarter", 32'(bus.chg_quarter), 1);
    bus.coin_nickel = 1'b1;
    tick();
    bus.coin_nickel = 1'b0;
    chk("chg_coin_reject", 32'(bus.coin_reject), 1);
    chk("chg_moneyin", 32'(bus.moneyin), 0);
    seen = bus.chg_nickel | bus.chg_dime | bus.chg_quarter;
    tick(); seen |= bus.chg_nickel | bus.chg_dime | bus.chg_quarter;
    tick(); seen |= bus.chg_nickel | bus.chg_dime | bus.chg_quarter;
    chk("gap_quiet", 32'(seen), 0);
    tick();
    chk("e5_quarter", 32'(bus.chg_quarter), 1);
    chk("e5_busy", 32'(bus.busy), 1);
    tick();
    chk("e6_busy", 32'(bus.busy), 0);
    chk("e6_moneyin", 32'(bus.moneyin), 0);

    // overflow boundary near MAX_CREDIT
    repeat (9) drive(C_DL, 3'b000, 1'b0);
    chk("c900", 32'(bus.moneyin), 900);
    drive(C_DL, 3'b000, 1'b0);
    chk("ovf_dollar_reject", 32'(bus.coin_reject), 1);
    chk("ovf_dollar_hold", 32'(bus.moneyin), 900);
    drive(C_Q, 3'b000, 1'b0); chk("c925", 32'(bus.moneyin), 925);
    drive(C_Q, 3'b000, 1'b0); chk("c950", 32'(bus.moneyin), 950);
    drive(C_Q, 3'b000, 1'b0); chk("c975", 32'(bus.moneyin), 975);
    chk("c975_noreject", 32'(bus.coin_reject), 0);
    drive(C_Q, 3'b000, 1'b0);
    chk("ovf_q_reject", 32'(bus.coin_reject), 1);
    chk("ovf_q_hold", 32'(bus.moneyin), 975);
    drive(NOC, 3'b000, 1'b1);
    drain(sum, nq, nd, nn, ok);
    chk("drain975_done", 32'(ok), 1);
    chk("drain975_sum", sum, 975);
    chk("drain975_nq", nq, 39);
    chk("drain975_moneyin", 32'(bus.moneyin), 0);

    // simultaneous coins: highest wins, single reject pulse
    drive(C_D | C_N, 3'b000, 1'b0);
    chk("dual_moneyin", 32'(bus.moneyin), 10);
    chk("dual_reject", 32'(bus.coin_reject), 1);
    tick();
    chk("dual_reject_once", 32'(bus.coin_reject), 0);
    drive(NOC, 3'b000, 1'b1);
    chk("cxl10_busy", 32'(bus.busy), 1);
    tick();
    chk("cxl10_dime", 32'(bus.chg_dime), 1);
    tick();
    chk("cxl10_busy_end", 32'(bus.busy), 0);
    chk("cxl10_moneyin", 32'(bus.moneyin), 0);

    // unaffordable vend ignored; vend beats cancel
    repeat (3) drive(C_Q, 3'b000, 1'b0);
    drive(NOC, 3'b010, 1'b0);
    chk("bev2_ignored", 32'(bus.moneyin), 75);
    chk("bev2_busy", 32'(bus.busy), 0);
    drive(C_Q, 3'b000, 1'b0); chk("c100", 32'(bus.moneyin), 100);
    drive(NOC, 3'b001, 1'b1);
    chk("vend_cxl_busy", 32'(bus.busy), 1);
    drain(sum, nq, nd, nn, ok);
    chk("vend_cxl_done", 32'(ok), 1);
    chk("vend_cxl_sum", sum, 25);
    chk("vend_cxl_nq", nq, 1);

    // mixed greedy change: 40 = quarter + dime + nickel
    drive(C_Q, 3'b000, 1'b0);
    drive(C_D, 3'b000, 1'b0);
    drive(C_N, 3'b000, 1'b0); chk("c40", 32'(bus.moneyin), 40);
    drive(NOC, 3'b000, 1'b1);
    drain(sum, nq, nd, nn, ok);
    chk("mix_done", 32'(ok), 1);
    chk("mix_sum", sum, 40);
    chk("mix_counts", {nq[7:0], nd[7:0], nn[7:0]}, 32'h010101);

    // reset in the middle of change
    drive(C_DL, 3'b000, 1'b0);
    drive(C_D, 3'b000, 1'b0);
    drive(C_N, 3'b000, 1'b0); chk("c115", 32'(bus.moneyin), 115);
    drive(NOC, 3'b000, 1'b1);
    tick();
    chk("r_first_quarter", 32'(bus.chg_quarter), 1);
    #2 rst = 1'b0;
    #1;
    chk("r_async_moneyin", 32'(bus.moneyin), 0);
    chk("r_async_busy", 32'(bus.busy), 0);
    chk("r_async_chg", 32'({bus.chg_nickel, bus.chg_dime, bus.chg_quarter}), 0);
    tick(); tick();
    rst = 1'b1;
    tick();
    chk("r_post_moneyin", 32'(bus.moneyin), 0);
    chk("r_post_busy", 32'(bus.busy), 0);
    seen = 1'b0;
    repeat (6) begin
      tick();
      seen |= bus.chg_nickel | bus.chg_dime | bus.chg_quarter | bus.busy;
    end
    chk("r_forfeit", 32'(seen), 0);
    drive(C_N, 3'b000, 1'b0);
    chk("r_nickel", 32'(bus.moneyin), 5);

    chk("one_hot_chg", multi_hot, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  task automatic drive_idle();
    {bus.coin_dollar, bus.coin_quarter, bus.coin_dime, bus.coin_nickel} = 4'b0000;
    {bus.outbev3, bus.outbev2, bus.outbev1} = 3'b000;
    bus.cancel = 1'b0;
  endtask

endmodule
